// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage of the segmented RISC-V pipeline, downstream of EX/MEM.
//
// Resolves the PC source for branches and jumps. Runs a req/ack handshake to data memory
// with byte-lane enables, store-data lane replication and load sign/zero extension. Stalls
// the pipeline while an access is outstanding.
//
// Optional feature: define MEM_TIMEOUT_EN to enable a watchdog that aborts a request after
// TIMEOUT_CYCLES cycles without ack and pulses bus_error_out. When undefined, a request
// waits indefinitely and bus_error_out is tied low.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   valid_in              EX/MEM slot holds a real instruction
//   jump_pc_in            jump target comes from the ALU result (JALR)
//   instruction_func_in   [2:0] = funct3, [4:3] reserved and ignored
//   force_jump_in         unconditional jump
//   branch_in, zero_in    conditional branch, ALU zero flag
//   mem_write_in          store
//   mem_read_in           load
//   addr_in, wdata_in     effective byte address, right-aligned store data
//   dmem_ack, dmem_rdata  memory completion and read word
//   pc_src_out            take branch/jump target
//   jalr_sel_out          jump_pc_in qualified by valid_in
//   stall_out             freeze IF..EX/MEM registers
//   dmem_req/we/addr/be/wdata  memory request (word-aligned address, lane-shifted data)
//   load_data_out         extended load result
//   load_valid_out        one-cycle pulse, load_data_out valid
//   misaligned_out        one-cycle pulse, access aborted as misaligned
//   bus_error_out         one-cycle pulse on watchdog timeout

module mem_access_stage #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              jump_pc_in,
    input  logic [4:0]        instruction_func_in,
    input  logic              force_jump_in,
    input  logic              branch_in,
    input  logic              zero_in,
    input  logic              mem_write_in,
    input  logic              mem_read_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       wdata_in,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              pc_src_out,
    output logic              jalr_sel_out,
    output logic              stall_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    output logic [31:0]       load_data_out,
    output logic              load_valid_out,
    output logic              misaligned_out,
    output logic              bus_error_out
);

    typedef enum logic {StIdle, StReq} state_e;

    state_e state_q, state_d;

    logic [2:0]  funct3;
    logic        start;
    logic        aligned;
    logic        start_ok;
    logic        timeout_hit;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic [31:0]       load_data_q;
    logic              load_valid_q;
    logic              misaligned_q;

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

    logic unused_func;
    assign unused_func = ^instruction_func_in[4:3];

    assign funct3 = instruction_func_in[2:0];

    // funct3[0] distinguishes BEQ (0) from BNE (1).
    assign pc_src_out   = valid_in & (force_jump_in | (branch_in & (zero_in ^ funct3[0])));
    assign jalr_sel_out = valid_in & jump_pc_in;

    assign start = valid_in & (mem_read_in | mem_write_in) & (state_q == StIdle);

    always_comb begin
        aligned    = 1'b0;
        be_next    = 4'b1111;
        wdata_next = wdata_in;
        unique case (funct3[1:0])
            2'b00: begin
                aligned    = 1'b1;
                be_next    = 4'b0001 << addr_in[1:0];
                wdata_next = {4{wdata_in[7:0]}};
            end
            2'b01: begin
                aligned    = ~addr_in[0];
                be_next    = 4'b0011 << addr_in[1:0];
                wdata_next = {2{wdata_in[15:0]}};
            end
            2'b10: begin
                aligned = (addr_in[1:0] == 2'b00);
            end
            default: begin
                aligned = 1'b0; // funct3[1:0]=11 is not a legal access size
            end
        endcase
    end

    assign start_ok = start & aligned;

    // A timed-out cycle releases the stall just like an ack cycle.
    assign stall_out = start_ok | ((state_q == StReq) & ~dmem_ack & ~timeout_hit);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_ok) state_d = StReq;
            StReq:  if (dmem_ack || timeout_hit) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Lane select and extension for the load result, using the latched offset and funct3.
    always_comb begin
        unique case (off_q)
            2'd0:    rd_byte = dmem_rdata[7:0];
            2'd1:    rd_byte = dmem_rdata[15:8];
            2'd2:    rd_byte = dmem_rdata[23:16];
            default: rd_byte = dmem_rdata[31:24];
        endcase
        rd_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        unique case (f3_q[1:0])
            2'b00:   load_ext = {{24{~f3_q[2] & rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = {{16{~f3_q[2] & rd_half[15]}}, rd_half};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= 4'b0000;
            wdata_q      <= 32'h0;
            off_q        <= 2'b00;
            f3_q         <= 3'b000;
            load_data_q  <= 32'h0;
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_valid_q <= 1'b0;
            misaligned_q <= start & ~aligned;
            if (start_ok) begin
                req_q   <= 1'b1;
                we_q    <= mem_write_in; // read+write together behaves as a store
                addr_q  <= {addr_in[ADDR_W-1:2], 2'b00};
                be_q    <= be_next;
                wdata_q <= wdata_next;
                off_q   <= addr_in[1:0];
                f3_q    <= funct3;
            end else if ((state_q == StReq) && (dmem_ack || timeout_hit)) begin
                req_q <= 1'b0;
                if (dmem_ack && !we_q) begin
                    load_data_q  <= load_ext;
                    load_valid_q <= 1'b1;
                end
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CntW-1:0] tmo_cnt_q;
    logic            bus_error_q;

    // Ack takes priority: the limit only fires on a cycle without ack.
    assign timeout_hit = (state_q == StReq) & ~dmem_ack &
                         (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q   <= '0;
            bus_error_q <= 1'b0;
        end else begin
            bus_error_q <= timeout_hit;
            if (start_ok) begin
                tmo_cnt_q <= '0;
            end else if ((state_q == StReq) && !dmem_ack) begin
                tmo_cnt_q <= tmo_cnt_q + CntW'(1);
            end
        end
    end

    assign bus_error_out = bus_error_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
    assign bus_error_out  = 1'b0;
`endif

    assign dmem_req       = req_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_be        = be_q;
    assign dmem_wdata     = wdata_q;
    assign load_data_out  = load_data_q;
    assign load_valid_out = load_valid_q;
    assign misaligned_out = misaligned_q;

endmodule
